// File: rtl/mul_hilo_ctrl.sv
// mul_hilo_ctrl: control stage in front of the combinational 32x32 signed
// multiplier. Latches operands on an accepted start, holds them for a fixed
// settle window, then captures the 64-bit product into HI/LO and pulses done.
// Also provides bus-side writes to HI/LO and a 32-bit overflow flag.
module mul_hilo_ctrl #(
    parameter int unsigned SETTLE_CYCLES = 2  // legal range 1..15
) (
    input  logic        clk,
    input  logic        clr,
    input  logic        start,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic        ready,
    output logic [31:0] mul_x,
    output logic [31:0] mul_y,
    input  logic [63:0] mul_product,
    input  logic [31:0] hi_in,
    input  logic [31:0] lo_in,
    input  logic        hi_wr,
    input  logic        lo_wr,
    output logic [31:0] hi_out,
    output logic [31:0] lo_out,
    output logic        done,
    output logic        ovf
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    // Counter reload: the capture happens when the counter has reached zero,
    // so loading SETTLE_CYCLES-1 yields exactly SETTLE_CYCLES held edges.
    localparam logic [3:0] CNT_LOAD = 4'(SETTLE_CYCLES - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [3:0]  r_cnt;
    logic [3:0]  w_cnt_nxt;
    logic [31:0] r_mul_x;
    logic [31:0] r_mul_y;
    logic [31:0] r_hi;
    logic [31:0] r_lo;
    logic        r_done;
    logic        r_ovf;
    logic        w_accept;
    logic        w_capture;
    logic        w_ovf;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_capture = (r_state == ST_BUSY) && (r_cnt == 4'd0);
    // HI must equal the sign extension of LO[31] for the product to fit 32 bits.
    assign w_ovf     = (mul_product[63:32] != {32{mul_product[31]}});

    // State register and settle counter.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state and counter logic; starts while BUSY are ignored.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = CNT_LOAD;
                end else begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = r_cnt;
                end
            end
            ST_BUSY: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ST_IDLE;
                    w_cnt_nxt   = 4'd0;
                end else begin
                    w_state_nxt = ST_BUSY;
                    w_cnt_nxt   = r_cnt - 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    // Operand registers: loaded only on an accepted start, otherwise held
    // so the multiplier inputs do not toggle while idle.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_mul_x <= 32'd0;
            r_mul_y <= 32'd0;
        end else if (w_accept) begin
            r_mul_x <= opa;
            r_mul_y <= opb;
        end else begin
            r_mul_x <= r_mul_x;
            r_mul_y <= r_mul_y;
        end
    end

    // HI/LO registers: product capture wins over a same-edge bus write.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hi <= 32'd0;
            r_lo <= 32'd0;
        end else if (w_capture) begin
            r_hi <= mul_product[63:32];
            r_lo <= mul_product[31:0];
        end else begin
            if (hi_wr) begin
                r_hi <= hi_in;
            end else begin
                r_hi <= r_hi;
            end
            if (lo_wr) begin
                r_lo <= lo_in;
            end else begin
                r_lo <= r_lo;
            end
        end
    end

    // Done pulse and overflow flag, both updated only by a product capture.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_done <= 1'b0;
            r_ovf  <= 1'b0;
        end else begin
            r_done <= w_capture;
            if (w_capture) begin
                r_ovf <= w_ovf;
            end else begin
                r_ovf <= r_ovf;
            end
        end
    end

    assign ready  = (r_state == ST_IDLE);
    assign mul_x  = r_mul_x;
    assign mul_y  = r_mul_y;
    assign hi_out = r_hi;
    assign lo_out = r_lo;
    assign done   = r_done;
    assign ovf    = r_ovf;

endmodule

// File: tb/tb_mul_hilo_ctrl.sv
// Directed testbench for mul_hilo_ctrl with SETTLE_CYCLES=2. A behavioural
// signed multiplier closes the loop from mul_x/mul_y back to mul_product.
module tb_mul_hilo_ctrl;

    logic        clk;
    logic        clr;
    logic        start;
    logic [31:0] opa;
    logic [31:0] opb;
    logic        ready;
    logic [31:0] mul_x;
    logic [31:0] mul_y;
    logic [63:0] mul_product;
    logic [31:0] hi_in;
    logic [31:0] lo_in;
    logic        hi_wr;
    logic        lo_wr;
    logic [31:0] hi_out;
    logic [31:0] lo_out;
    logic        done;
    logic        ovf;

    int n_cmp;
    int n_err;
    int n_done;

    mul_hilo_ctrl #(.SETTLE_CYCLES(2)) dut (
        .clk         (clk),
        .clr         (clr),
        .start       (start),
        .opa         (opa),
        .opb         (opb),
        .ready       (ready),
        .mul_x       (mul_x),
        .mul_y       (mul_y),
        .mul_product (mul_product),
        .hi_in       (hi_in),
        .lo_in       (lo_in),
        .hi_wr       (hi_wr),
        .lo_wr       (lo_wr),
        .hi_out      (hi_out),
        .lo_out      (lo_out),
        .done        (done),
        .ovf         (ovf)
    );

    // External combinational signed multiplier.
    assign mul_product = $signed({{32{mul_x[31]}}, mul_x}) * $signed({{32{mul_y[31]}}, mul_y});

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp = n_cmp + 1;
        if (obs !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance one rising edge and settle 1 time unit past it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a start from the current (ready) cycle and check the full
    // SETTLE_CYCLES=2 sequence ending in the done cycle.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] e_hi, input logic [31:0] e_lo, input logic e_ovf);
        chk({tag, "_rdy_pre"}, 64'(ready), 64'd1);
        start = 1'b1;
        opa   = a;
        opb   = b;
        tick();
        start = 1'b0;
        chk({tag, "_rdy0a"}, 64'(ready), 64'd0);
        chk({tag, "_done0"}, 64'(done), 64'd0);
        chk({tag, "_mulx"}, 64'(mul_x), 64'(a));
        chk({tag, "_muly"}, 64'(mul_y), 64'(b));
        tick();
        chk({tag, "_rdy0b"}, 64'(ready), 64'd0);
        tick();
        chk({tag, "_done"}, 64'(done), 64'd1);
        chk({tag, "_rdy1"}, 64'(ready), 64'd1);
        chk({tag, "_hi"}, 64'(hi_out), 64'(e_hi));
        chk({tag, "_lo"}, 64'(lo_out), 64'(e_lo));
        chk({tag, "_ovf"}, 64'(ovf), 64'(e_ovf));
    endtask

    initial begin
        n_cmp  = 0;
        n_err  = 0;
        n_done = 0;
        clr    = 1'b1;
        start  = 1'b0;
        opa    = 32'd0;
        opb    = 32'd0;
        hi_in  = 32'd0;
        lo_in  = 32'd0;
        hi_wr  = 1'b0;
        lo_wr  = 1'b0;
        tick();
        tick();
        clr = 1'b0;
        tick();

        // Reset state
        chk("rst_ready", 64'(ready), 64'd1);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_ovf", 64'(ovf), 64'd0);
        chk("rst_hi", 64'(hi_out), 64'd0);
        chk("rst_lo", 64'(lo_out), 64'd0);
        chk("rst_mulx", 64'(mul_x), 64'd0);

        // 7 * -3 = -21
        run_op("neg", 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0);
        tick();
        chk("neg_done_clr", 64'(done), 64'd0);

        // 0x80000000^2 = 2^62, then back-to-back 0x10000^2 = 2^32
        run_op("min", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        run_op("b2b", 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1);
        tick();

        // start held while BUSY with changing operands
        start = 1'b1;
        opa   = 32'd5;
        opb   = 32'd6;
        tick();
        n_done = n_done + int'(done);
        opa = 32'd99;
        chk("hold_mulx_a", 64'(mul_x), 64'd5);
        tick();
        n_done = n_done + int'(done);
        opa = 32'd123;
        chk("hold_mulx_b", 64'(mul_x), 64'd5);
        tick();
        n_done = n_done + int'(done);
        start = 1'b0;
        chk("hold_lo", 64'(lo_out), 64'd30);
        for (int i = 0; i < 5; i++) begin
            tick();
            n_done = n_done + int'(done);
        end
        chk("hold_done_cnt", 64'(n_done), 64'd1);
        chk("idle_mulx_kept", 64'(mul_x), 64'd5);

        // Bus write on the capture edge is dropped
        start = 1'b1;
        opa   = 32'd7;
        opb   = 32'hFFFF_FFFD;
        tick();
        start = 1'b0;
        tick();
        hi_wr = 1'b1;
        hi_in = 32'hDEAD_BEEF;
        lo_wr = 1'b1;
        lo_in = 32'h1234_5678;
        tick();
        chk("col_done", 64'(done), 64'd1);
        chk("col_hi", 64'(hi_out), 64'hFFFF_FFFF);
        chk("col_lo", 64'(lo_out), 64'hFFFF_FFEB);
        // Same write while IDLE takes effect, ovf/done untouched
        tick();
        hi_wr = 1'b0;
        lo_wr = 1'b0;
        chk("wr_hi", 64'(hi_out), 64'hDEAD_BEEF);
        chk("wr_lo", 64'(lo_out), 64'h1234_5678);
        chk("wr_done", 64'(done), 64'd0);
        chk("wr_ovf", 64'(ovf), 64'd0);

        // Make ovf=1 so the abort visibly clears it
        run_op("pre_abort", 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1);
        tick();
        hi_wr = 1'b1;
        hi_in = 32'hCAFE_F00D;
        tick();
        hi_wr = 1'b0;

        // Abort with clr mid-cycle during BUSY
        start = 1'b1;
        opa   = 32'd3;
        opb   = 32'd4;
        tick();
        start = 1'b0;
        chk("abt_busy", 64'(ready), 64'd0);
        #2;
        clr = 1'b1;
        #1;
        chk("abt_ready", 64'(ready), 64'd1);
        chk("abt_hi", 64'(hi_out), 64'd0);
        chk("abt_mulx", 64'(mul_x), 64'd0);
        chk("abt_ovf", 64'(ovf), 64'd0);
        tick();
        clr    = 1'b0;
        n_done = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            n_done = n_done + int'(done);
        end
        chk("abt_no_done", 64'(n_done), 64'd0);
        chk("abt_hi_after", 64'(hi_out), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/mul_hilo_ctrl.md
Name: mul_hilo_ctrl

Overview:
- Sequential control stage directly upstream of the combinational 32x32 signed Booth multiplier.
- Accepts a multiply request from the CPU control unit over a start/ready handshake and holds the operands stable in registers that drive the multiplier inputs.
- Waits a fixed number of settle cycles (multicycle path), then captures the 64-bit signed product into the HI and LO registers and pulses done.
- Also provides the bus-side write path for HI/LO (move-to-HI/LO) and a 32-bit overflow flag.

Parameters:
- SETTLE_CYCLES, 2, number of clock edges the multiplier inputs are held before product capture; legal range 1..15.

Ports:
- clk  input  1  system clock, rising-edge active
- clr  input  1  reset, asynchronous, active-high
- start  input  1  multiply request; accepted only while ready=1
- opa  input  32  multiplicand (signed)
- opb  input  32  multiplier (signed)
- ready  output  1  high when a new start will be accepted
- mul_x  output  32  registered multiplicand to multiplier x input
- mul_y  output  32  registered multiplier to multiplier y input
- mul_product  input  64  signed product returned from the multiplier
- hi_in  input  32  bus data for HI write
- lo_in  input  32  bus data for LO write
- hi_wr  input  1  HI write enable from bus
- lo_wr  input  1  LO write enable from bus
- hi_out  output  32  HI register (product[63:32])
- lo_out  output  32  LO register (product[31:0])
- done  output  1  one-cycle pulse after a product capture
- ovf  output  1  high when HI is not the sign extension of LO[31]; valid after capture

Behaviour:
- Reset (clr=1, asynchronous): state=IDLE, counter=0, mul_x=0, mul_y=0, hi_out=0, lo_out=0, done=0, ovf=0, ready=1.
- FSM states: IDLE and BUSY. ready=1 exactly in IDLE.
- IDLE, start=1 at edge E0:
  - mul_x<=opa, mul_y<=opb, counter<=SETTLE_CYCLES-1, state->BUSY.
- IDLE, start=0: hold all state. done=0 at every edge that is not a capture edge.
- BUSY with counter!=0: counter decrements. mul_x and mul_y are held constant; opa and opb are ignored.
- BUSY with counter==0, at edge E0+SETTLE_CYCLES (capture edge):
  - hi_out<=mul_product[63:32], lo_out<=mul_product[31:0].
  - ovf<=(mul_product[63:32] != {32{mul_product[31]}}).
  - done<=1, state->IDLE.
- Latency: done is high in the cycle following edge E0+SETTLE_CYCLES, and ready is high in that same cycle. A start in the done cycle is accepted (back-to-back operation, one idle-free turnaround).
- start while BUSY: ignored, no queuing.
- Bus writes:
  - hi_wr/lo_wr load hi_in/lo_in at any edge, in any state.
  - On the capture edge, the capture has priority and the same-edge bus write is dropped.
  - A bus write does not change ovf or done.
- Arithmetic: the product is signed two's complement; this block performs no arithmetic beyond the ovf compare.
- clr asserted mid-operation: the operation is aborted immediately, all registers return to reset values, and no done pulse is produced.
- mul_x and mul_y keep their last values in IDLE (no toggling) to limit multiplier switching.

Test Plan:
- Reset: assert clr mid-cycle -> all outputs 0 immediately, ready=1.
- opa=7, opb=-3 (0xFFFFFFFD), start 1 cycle, SETTLE_CYCLES=2:
  - ready=0 for 2 cycles.
  - done pulses on the 3rd cycle with hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, ovf=0.
- opa=opb=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000, ovf=1.
- Back-to-back: second start (opa=0x10000, opb=0x10000) asserted in the done cycle -> accepted; next done gives hi_out=0x00000001, lo_out=0x00000000, ovf=1.
- start held high while BUSY with changing opa -> mul_x unchanged, exactly one done pulse per accepted start.
- Collisions and abort:
  - hi_wr=1, hi_in=0xDEADBEEF on the capture edge -> hi_out equals the product high word.
  - The same write while IDLE -> hi_out=0xDEADBEEF.
  - clr during BUSY -> no done pulse, hi_out=0.
